fpm_issue_queue: RTL and testbench

FPM_ISSUE_QUEUE -- requirements
Module: fpm_issue_queue

---
 rtl/fpm_issue_queue.sv | 126 ++++++++++++
 tb/tb_fpm_issue_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_issue_queue.sv
// fpm_issue_queue: operand-pair FIFO that feeds a fixed-latency FP multiplier.
// Operands are issued from the head with flush-to-zero detection. A
// valid/tag shift register tracks each issued pair so the tag comes out
// aligned with the multiplier product.
module fpm_issue_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   issue_en,
    output logic [31:0]            issue_a,
    output logic [31:0]            issue_b,
    output logic                   issue_zero_a,
    output logic                   issue_zero_b,
    output logic                   issue_valid,
    output logic                   res_valid,
    output logic [TAG_W-1:0]       res_tag,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue storage
    logic [31:0]      r_mem_a   [DEPTH];
    logic [31:0]      r_mem_b   [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];

    // Queue control state
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Result tracking pipeline; the last stage drives res_valid/res_tag
    logic [LATENCY-1:0] r_sh_vld;
    logic [TAG_W-1:0]   r_sh_tag [LATENCY];

    // Combinational handshake and head view
    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic [31:0]      w_head_a;
    logic [31:0]      w_head_b;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_head_zero_a;
    logic             w_head_zero_b;

    assign w_not_empty = (r_count != '0);
    assign w_head_a    = r_mem_a[r_rptr];
    assign w_head_b    = r_mem_b[r_rptr];
    assign w_head_tag  = r_mem_tag[r_rptr];

    // Exponent all-zero covers true zero and denormals (flush-to-zero)
    assign w_head_zero_a = (w_head_a[30:23] == 8'h00);
    assign w_head_zero_b = (w_head_b[30:23] == 8'h00);

    // Acceptance is based on registered occupancy only, so a same-cycle pop
    // never opens a slot; this keeps in_ready off the issue_en path.
    assign in_ready    = (r_count < FULL_CNT) && !flush && !rst;
    assign issue_valid = w_not_empty && issue_en && !flush;

    assign w_push = in_valid && in_ready;
    assign w_pop  = issue_valid;

    assign issue_a      = issue_valid ? w_head_a : '0;
    assign issue_b      = issue_valid ? w_head_b : '0;
    assign issue_zero_a = issue_valid ? w_head_zero_a : 1'b1;
    assign issue_zero_b = issue_valid ? w_head_zero_b : 1'b1;

    assign count     = r_count;
    assign res_valid = r_sh_vld[LATENCY-1];
    assign res_tag   = r_sh_vld[LATENCY-1] ? r_sh_tag[LATENCY-1] : '0;

    // Write the offered pair and tag into the tail slot on a push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr]   <= in_a;
            r_mem_b[r_wptr]   <= in_b;
            r_mem_tag[r_wptr] <= in_tag;
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Track issued pairs through the multiplier latency; flush leaves in-flight entries alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_vld <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_sh_tag[i] <= '0;
            end
        end else begin
            r_sh_vld[0] <= issue_valid;
            r_sh_tag[0] <= issue_valid ? w_head_tag : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_sh_vld[i] <= r_sh_vld[i-1];
                r_sh_tag[i] <= r_sh_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fpm_issue_queue.sv
// tb_fpm_issue_queue: directed self-checking bench for fpm_issue_queue
// (DEPTH=4, TAG_W=4, LATENCY=2). Inputs change 1ns after the rising edge,
// and outputs are checked 2ns later.
module tb_fpm_issue_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic        issue_en;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic        issue_zero_a;
    logic        issue_zero_b;
    logic        issue_valid;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned pulses;

    fpm_issue_queue #(
        .DEPTH   (4),
        .TAG_W   (4),
        .LATENCY (2)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .issue_en     (issue_en),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_zero_a (issue_zero_a),
        .issue_zero_b (issue_zero_b),
        .issue_valid  (issue_valid),
        .res_valid    (res_valid),
        .res_tag      (res_tag),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be changed
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #2;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    // Bring the queue to: 3 queued (tags 3,4,5), tag 1 in the last stage, tag 2 in the first
    task automatic setup_inflight();
        issue_en = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            offer(32'h3F800000, 32'h3F800000, 4'(t));
            tick();
        end
        in_valid = 1'b0;
        issue_en = 1'b1;
        tick();                                   // pop tag 1
        offer(32'h3F800000, 32'h3F800000, 4'd5);
        tick();                                   // pop tag 2, push tag 5
        in_valid = 1'b0;
        settle();
        check("setup_count", 32'(count), 32'd3);
        check("setup_res_tag1", 32'(res_tag), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        issue_en = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        settle();
        check("rst_in_ready_during", 32'(in_ready), 32'd0);
        rst = 1'b0;
        settle();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_tag", 32'(res_tag), 32'd0);
        check("rst_issue_a", issue_a, 32'h0);
        check("rst_issue_b", issue_b, 32'h0);
        check("rst_zero_a", 32'(issue_zero_a), 32'd1);
        check("rst_zero_b", 32'(issue_zero_b), 32'd1);

        // ---------------- single pair ----------------
        issue_en = 1'b1;
        offer(32'h3FC00000, 32'h40000000, 4'd5);
        settle();
        check("single_nobypass", 32'(issue_valid), 32'd0);
        tick();                                   // edge k: push
        in_valid = 1'b0;
        settle();
        check("single_count1", 32'(count), 32'd1);
        check("single_issue_valid", 32'(issue_valid), 32'd1);
        check("single_issue_a", issue_a, 32'h3FC00000);
        check("single_issue_b", issue_b, 32'h40000000);
        check("single_zero_a", 32'(issue_zero_a), 32'd0);
        check("single_zero_b", 32'(issue_zero_b), 32'd0);
        check("single_res_early", 32'(res_valid), 32'd0);
        tick();                                   // edge k+1: pop
        settle();
        check("single_count0", 32'(count), 32'd0);
        check("single_idle_a", issue_a, 32'h0);
        check("single_res_k1", 32'(res_valid), 32'd0);
        tick();                                   // edge k+2
        settle();
        check("single_res_valid", 32'(res_valid), 32'd1);
        check("single_res_tag", 32'(res_tag), 32'd5);
        tick();
        settle();
        check("single_res_once", 32'(res_valid), 32'd0);
        check("single_res_tag0", 32'(res_tag), 32'd0);

        // ---------------- zero detect ----------------
        offer(32'h80000000, 32'h00400000, 4'd7);
        tick();
        offer(32'h00800000, 32'h3F800000, 4'd9);
        settle();
        check("zero_a_negzero", 32'(issue_zero_a), 32'd1);
        check("zero_b_denorm", 32'(issue_zero_b), 32'd1);
        check("zero_issue_a", issue_a, 32'h80000000);
        tick();                                   // pop tag 7, push tag 9
        in_valid = 1'b0;
        settle();
        check("zero_count", 32'(count), 32'd1);
        check("zero_a_minnorm", 32'(issue_zero_a), 32'd0);
        check("zero_b_one", 32'(issue_zero_b), 32'd0);
        tick();
        settle();
        check("zero_res1_valid", 32'(res_valid), 32'd1);
        check("zero_res1_tag", 32'(res_tag), 32'd7);
        tick();
        settle();
        check("zero_res2_tag", 32'(res_tag), 32'd9);
        tick();
        settle();
        check("zero_drained", 32'(res_valid), 32'd0);

        // ---------------- full ----------------
        issue_en = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            offer(32'h3F800000, 32'h40000000, 4'(t));
            settle();
            check("full_ready_pre", 32'(in_ready), 32'd1);
            tick();
        end
        offer(32'h3F800000, 32'h40000000, 4'd5);
        settle();
        check("full_count4", 32'(count), 32'd4);
        check("full_not_ready", 32'(in_ready), 32'd0);
        tick();
        settle();
        check("full_held_count", 32'(count), 32'd4);
        issue_en = 1'b1;
        settle();
        check("full_issue_valid", 32'(issue_valid), 32'd1);
        check("full_ready_no_pop_dep", 32'(in_ready), 32'd0);
        tick();                                   // pop tag 1
        settle();
        check("full_count3", 32'(count), 32'd3);
        check("full_ready_again", 32'(in_ready), 32'd1);
        tick();                                   // pop tag 2, push tag 5
        in_valid = 1'b0;
        settle();
        check("full_count_pp", 32'(count), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("full_res_valid", 32'(res_valid), 32'd1);
            check("full_res_tag", 32'(res_tag), 32'(i + 1));
            tick();
            settle();
        end
        check("full_res_end", 32'(res_valid), 32'd0);
        check("full_count_end", 32'(count), 32'd0);

        // ---------------- simultaneous push/pop at count=2 ----------------
        issue_en = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            offer(32'h3F800000, 32'h3F800000, 4'(t));
            tick();
        end
        issue_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h3F800000, 32'h3F800000, 4'(i + 3));
            settle();
            check("pp_count", 32'(count), 32'd2);
            if (i >= 2) begin
                check("pp_res_valid", 32'(res_valid), 32'd1);
                check("pp_res_tag", 32'(res_tag), 32'(i - 1));
            end else begin
                check("pp_res_idle", 32'(res_valid), 32'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        settle();
        check("pp_count_end", 32'(count), 32'd2);
        check("pp_res_tag_end", 32'(res_tag), 32'd9);
        for (int i = 0; i < 5; i++) tick();
        settle();
        check("pp_drained", 32'(count), 32'd0);

        // ---------------- flush ----------------
        setup_inflight();
        flush = 1'b1;
        offer(32'h3F800000, 32'h3F800000, 4'd6);
        settle();
        check("flush_no_ready", 32'(in_ready), 32'd0);
        check("flush_no_issue", 32'(issue_valid), 32'd0);
        pulses = 32'(res_valid);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        check("flush_count0", 32'(count), 32'd0);
        check("flush_res2_valid", 32'(res_valid), 32'd1);
        check("flush_res2_tag", 32'(res_tag), 32'd2);
        pulses += 32'(res_valid);
        for (int i = 0; i < 6; i++) begin
            tick();
            settle();
            pulses += 32'(res_valid);
        end
        check("flush_pulses", pulses, 32'd2);
        check("flush_count_stays0", 32'(count), 32'd0);

        // ---------------- reset mid-operation ----------------
        setup_inflight();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rmid_count0", 32'(count), 32'd0);
        check("rmid_res_valid", 32'(res_valid), 32'd0);
        check("rmid_res_tag", 32'(res_tag), 32'd0);
        check("rmid_issue_valid", 32'(issue_valid), 32'd0);
        check("rmid_zero_a", 32'(issue_zero_a), 32'd1);
        check("rmid_in_ready", 32'(in_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            pulses += 32'(res_valid);
        end
        check("rmid_no_pulses", pulses, 32'd0);
        offer(32'h40400000, 32'h00000000, 4'd11);
        tick();
        in_valid = 1'b0;
        settle();
        check("rmid_new_count", 32'(count), 32'd1);
        check("rmid_new_issue_a", issue_a, 32'h40400000);
        check("rmid_new_zero_b", 32'(issue_zero_b), 32'd1);
        tick();
        tick();
        settle();
        check("rmid_new_res_tag", 32'(res_tag), 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
